// File: rtl/gcd_behmodel.sv
// Sequential GCD engine using iterative subtractive Euclid behind a start/done handshake.
// Optional step counter output enabled by defining GCD_STEP_COUNT_EN.
module gcd_behmodel #(
    parameter int unsigned W = 7
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [W-1:0] A,
    input  logic [W-1:0] B,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] GCD
`ifdef GCD_STEP_COUNT_EN
    ,
    output logic [W-1:0] steps
`endif
);

    typedef enum logic {
        IDLE = 1'b0,
        CALC = 1'b1
    } state_t;

    state_t       state;
    logic [W-1:0] a_r;
    logic [W-1:0] b_r;

    // Control, working registers and result; done defaults low so it pulses for one cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
            GCD   <= '0;
            a_r   <= '0;
            b_r   <= '0;
`ifdef GCD_STEP_COUNT_EN
            steps <= '0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        a_r   <= A;
                        b_r   <= B;
                        busy  <= 1'b1;
                        state <= CALC;
`ifdef GCD_STEP_COUNT_EN
                        steps <= '0;
`endif
                    end
                end
                CALC: begin
                    if (a_r == '0 || b_r == '0 || a_r == b_r) begin
                        // a_r|b_r yields the nonzero operand, or the common value when equal.
                        GCD   <= a_r | b_r;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        if (a_r > b_r) begin
                            a_r <= a_r - b_r;
                        end else begin
                            b_r <= b_r - a_r;
                        end
`ifdef GCD_STEP_COUNT_EN
                        steps <= steps + W'(1);
`endif
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gcd_behmodel.sv
// Self-checking bench for gcd_behmodel: directed pairs, handshake corners and random pairs
// against an arithmetic Euclid reference (quotient sums give the subtraction count).
module tb_gcd_behmodel;

    localparam int unsigned W = 7;

    logic         clk;
    logic         rst;
    logic         start;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic         busy;
    logic         done;
    logic [W-1:0] GCD;
`ifdef GCD_STEP_COUNT_EN
    logic [W-1:0] steps;
`endif

    int checks   = 0;
    int failures = 0;

    gcd_behmodel #(.W(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .A     (A),
        .B     (B),
        .busy  (busy),
        .done  (done),
        .GCD   (GCD)
`ifdef GCD_STEP_COUNT_EN
        ,
        .steps (steps)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        if (obs != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference GCD by remainder Euclid.
    function automatic int ref_gcd(input int a, input int b);
        int x = a;
        int y = b;
        int t;
        while (y != 0) begin
            t = x % y;
            x = y;
            y = t;
        end
        return x;
    endfunction

    // Subtraction count: sum of division quotients minus one (stops at equality), zero if any operand is 0.
    function automatic int ref_steps(input int a, input int b);
        int x = (a > b) ? a : b;
        int y = (a > b) ? b : a;
        int s = 0;
        int t;
        if (a == 0 || b == 0) return 0;
        while (y != 0) begin
            s += x / y;
            t = x % y;
            x = y;
            y = t;
        end
        return s - 1;
    endfunction

    // One computation; edge 1 is the accepting edge, done expected visible after edge S+2.
    task automatic run_op(input int a, input int b, input string tag, input bit poke_busy);
        int edges;
        int s;
        s = ref_steps(a, b);
        @(negedge clk);
        A = W'(a);
        B = W'(b);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        A = W'($urandom);
        B = W'($urandom);
        edges = 1;
        check({tag, "_busy"}, int'(busy), 1);
        while (!done && edges < 400) begin
            if (poke_busy && edges == 2) begin
                A = W'(3);
                B = W'(6);
                start = 1'b1;
            end
            @(posedge clk);
            #1;
            start = 1'b0;
            edges++;
        end
        check({tag, "_latency"}, edges, s + 2);
        check({tag, "_gcd"}, int'(GCD), ref_gcd(a, b));
        check({tag, "_busy_done"}, int'(busy), 0);
`ifdef GCD_STEP_COUNT_EN
        check({tag, "_steps"}, int'(steps), s);
`endif
        @(posedge clk);
        #1;
        check({tag, "_done_width"}, int'(done), 0);
        check({tag, "_gcd_hold"}, int'(GCD), ref_gcd(a, b));
    endtask

    int pa[11] = '{42, 25, 40, 36, 8, 1, 85, 54, 80, 19, 79};
    int pb[11] = '{10, 41, 25, 7, 2, 33, 20, 66, 32, 41, 64};
    int ba[3]  = '{42, 80, 9};
    int bb[3]  = '{10, 32, 9};

    initial begin
        int edges;
        int saw_done;
        rst = 1'b1;
        start = 1'b0;
        A = '0;
        B = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_gcd", int'(GCD), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        rst = 1'b0;

        for (int i = 0; i < 11; i++) run_op(pa[i], pb[i], $sformatf("pair%0d", i), 1'b0);

        run_op(9, 9, "eq9", 1'b0);
        run_op(0, 0, "z00", 1'b0);
        run_op(0, 45, "z0x", 1'b0);
        run_op(45, 0, "zx0", 1'b0);
        run_op(85, 20, "ignore_start", 1'b1);
        run_op(127, 1, "worst", 1'b0);

        // Start held high: back-to-back computations, GCD holds across the next accept.
        @(negedge clk);
        A = W'(ba[0]);
        B = W'(bb[0]);
        start = 1'b1;
        @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            if (k < 2) begin
                A = W'(ba[k+1]);
                B = W'(bb[k+1]);
            end
            edges = 1;
            while (!done && edges < 400) begin
                @(posedge clk);
                #1;
                edges++;
            end
            check($sformatf("b2b%0d_latency", k), edges, ref_steps(ba[k], bb[k]) + 2);
            check($sformatf("b2b%0d_gcd", k), int'(GCD), ref_gcd(ba[k], bb[k]));
            if (k == 2) start = 1'b0;
            @(posedge clk);
            #1;
            check($sformatf("b2b%0d_gcd_hold", k), int'(GCD), ref_gcd(ba[k], bb[k]));
            check($sformatf("b2b%0d_busy_next", k), int'(busy), (k < 2) ? 1 : 0);
        end

        // Reset mid-computation abandons the operation without a done pulse.
        @(negedge clk);
        A = W'(127);
        B = W'(1);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("midrst_busy", int'(busy), 0);
        check("midrst_done", int'(done), 0);
        check("midrst_gcd", int'(GCD), 0);
        saw_done = 0;
        repeat (150) begin
            @(posedge clk);
            #1;
            if (done) saw_done = 1;
        end
        check("midrst_no_done", saw_done, 0);

        for (int r = 0; r < 20; r++)
            run_op(int'($urandom_range(0, 127)), int'($urandom_range(0, 127)), $sformatf("rnd%0d", r), 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/gcd_behmodel.md
Name: gcd_behmodel

Overview:
- Sequential greatest-common-divisor engine for two unsigned W-bit operands, using iterative subtractive Euclid.
- Sits as a leaf arithmetic block behind a simple start/done handshake.
- Result register holds the last GCD until the next computation completes.

Parameters:
- W, 7, operand and result width in bits (W >= 2).

Ports:
- clk  input  1  single clock; all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- start  input  1  request; sampled only when busy=0
- A  input  W  operand A, unsigned; captured on the accepted start edge
- B  input  W  operand B, unsigned; captured on the accepted start edge
- busy  output  1  high while a computation is in progress
- done  output  1  one-cycle pulse when GCD is updated
- GCD  output  W  registered result

Behaviour:
- Reset (rst=1 at a rising edge) forces:
  - state IDLE
  - busy=0, done=0, GCD=0
  - internal working registers a_r=0, b_r=0
- rst has priority over everything, including mid-computation; any in-flight operation is abandoned with no done pulse.
- States: IDLE, CALC.
- IDLE:
  - done=0 except in the single cycle after completion.
  - On an edge with start=1: a_r<=A, b_r<=B, busy<=1, go to CALC.
- CALC, evaluated each edge in priority order:
  1. a_r==0: GCD<=b_r, finish.
  2. b_r==0: GCD<=a_r, finish.
  3. a_r==b_r: GCD<=a_r, finish.
  4. a_r>b_r: a_r<=a_r-b_r.
  5. Otherwise: b_r<=b_r-a_r.
- Finish means: done<=1 for exactly one cycle, busy<=0, state<=IDLE.
- Subtraction never underflows because the larger operand is always the minuend; all arithmetic is unsigned W-bit.
- Latency: with S = number of subtraction steps, done is high after the (S+2)th rising edge following the start-accepting edge.
  - Example: 8,2 gives S=3, so done follows the 5th edge.
- GCD(0,0)=0; GCD(0,x)=x; GCD(x,0)=x. Each of these has S=0, latency 2.
- Worst case S = 2^W-2 (e.g. A=2^W-1, B=1).
- start while busy=1 is ignored; A and B may change freely during CALC without effect.
- start=1 in the same cycle done is high is accepted: a new computation begins and GCD keeps the previous value until the next finish.
- GCD changes only on a finish edge or on reset.

Optional Feature:
- Macro: GCD_STEP_COUNT_EN.
- When defined:
  - Adds output port steps (W bits).
  - steps is cleared to 0 on reset and on each accepted start.
  - steps increments by one per subtraction in CALC.
  - steps is held after finish until the next start.
  - Its value when done=1 equals S.
- When undefined: the port and counter do not exist; all other behaviour is identical.

Test Plan:
- Reset: assert rst 2 cycles -> GCD=0, busy=0, done=0; rst asserted mid-CALC -> busy=0 next cycle, no done pulse.
- Sequence of pairs via start, each waiting for done:
  - 42,10->2; 25,41->1; 40,25->5; 36,7->1; 8,2->2; 1,33->1
  - 85,20->5; 54,66->6; 80,32->16; 19,41->1; 79,64->1
  - done is exactly one cycle wide for each pair.
- Latency check: A=8,B=2 -> done after 5th edge; A=9,B=9 -> done after 2nd edge with GCD=9 (S=0).
- Zero operands: 0,0->0; 0,45->45; 45,0->45; each with latency 2.
- Handshake:
  - start pulsed while busy with A=3,B=6 is ignored; result is that of the original operands.
  - start held high continuously -> back-to-back computations; GCD holds between finishes.
- Worst case: A=127,B=1 -> GCD=1 after 128 edges; with GCD_STEP_COUNT_EN, steps=126 at done.
